// File: rtl/moving_sum_inverse.sv
// moving_sum_inverse: inverts a 3-tap moving sum, x[n] = s[n] - x[n-1] - x[n-2] mod 2^WIDTH.
// Latency 1 cycle (registered outputs); full throughput, no backpressure (every valid_i beat accepted).
// Ports: clk/rst (sync, active-high); valid_i/last_i/in = framed sums in;
//        valid_o/last_o/out = framed decoded samples; err_o = forced frame end; frame_cnt_o = frames done.
// Optional: define MOVING_SUM_INV_LEN_CHECK_EN to force a frame end at MAX_LEN samples.
module moving_sum_inverse #(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] in,
  output logic             valid_o,
  output logic             last_o,
  output logic [WIDTH-1:0] out,
  output logic             err_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] h2;
  logic [WIDTH-1:0] x;
  logic             force_end;
  logic             frame_end;

  // Modular subtraction: wrap is the exact inverse of the encoder's modular add.
  assign x = in - h1 - h2;

`ifdef MOVING_SUM_INV_LEN_CHECK_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  // Samples already accepted in the current frame.
  logic [LEN_W-1:0] count;

  // The incoming beat is the MAX_LEN-th sample; a real last there is a normal end.
  assign force_end = (count == LEN_LAST) && !last_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (valid_i) begin
      count <= (last_i || force_end) ? '0 : count + 1'b1;
    end
  end
`else
  assign force_end = 1'b0;
`endif

  assign frame_end = last_i || force_end;

  always_comb begin
    state_nxt = state;
    if (valid_i) begin
      state_nxt = frame_end ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h1          <= '0;
      h2          <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      err_o       <= 1'b0;
      out         <= '0;
      frame_cnt_o <= '0;
    end else begin
      valid_o <= valid_i;
      last_o  <= valid_i && frame_end;
      err_o   <= valid_i && force_end;
      if (valid_i) begin
        out <= x;
        // Clearing history at frame end lets a back-to-back frame start from zero.
        if (frame_end) begin
          h1          <= '0;
          h2          <= '0;
          frame_cnt_o <= frame_cnt_o + 1'b1;
        end else begin
          h2 <= h1;
          h1 <= x;
        end
      end
    end
  end

endmodule

// File: tb/tb_moving_sum_inverse.sv
module tb_moving_sum_inverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        last_i;
  logic [31:0] in;
  logic        valid_o;
  logic        last_o;
  logic [31:0] out;
  logic        err_o;
  logic [15:0] frame_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  moving_sum_inverse #(.WIDTH(32), .MAX_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .last_i(last_i), .in(in),
    .valid_o(valid_o), .last_o(last_o), .out(out), .err_o(err_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input at the falling edge; outputs seen right after
  // this call reflect the beat driven on the previous call.
  task automatic cyc(input logic v, input logic l, input logic [31:0] d);
    @(negedge clk);
    valid_i = v;
    last_i  = l;
    in      = d;
  endtask

  task automatic expect_o(input string tag, input logic v, input logic l,
                          input logic [31:0] o, input logic e);
    n_cmp++;
    assert (valid_o === v) else begin
      n_bad++; $error("FAIL %s valid_o got %0b exp %0b", tag, valid_o, v);
    end
    n_cmp++;
    assert (last_o === l) else begin
      n_bad++; $error("FAIL %s last_o got %0b exp %0b", tag, last_o, l);
    end
    n_cmp++;
    assert (out === o) else begin
      n_bad++; $error("FAIL %s out got %h exp %h", tag, out, o);
    end
    n_cmp++;
    assert (err_o === e) else begin
      n_bad++; $error("FAIL %s err_o got %0b exp %0b", tag, err_o, e);
    end
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] c);
    n_cmp++;
    assert (frame_cnt_o === c) else begin
      n_bad++; $error("FAIL %s frame_cnt_o got %0d exp %0d", tag, frame_cnt_o, c);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; in = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_o("reset", 0, 0, 32'd0, 0);
    expect_cnt("reset_cnt", 16'd0);
    rst = 1'b0;

    // Basic frame: 5,12,23 -> 5,7,11
    cyc(1, 0, 32'd5);
    cyc(1, 0, 32'd12);  expect_o("f1_s0", 1, 0, 32'd5, 0);
    cyc(1, 1, 32'd23);  expect_o("f1_s1", 1, 0, 32'd7, 0);
    cyc(0, 0, 32'd0);   expect_o("f1_s2", 1, 1, 32'd11, 0);
    expect_cnt("f1_cnt", 16'd1);
    cyc(0, 0, 32'd0);   expect_o("f1_gap", 0, 0, 32'd11, 0);

    // Modular wrap
    cyc(1, 0, 32'hFFFF_FFFF);
    cyc(1, 1, 32'h0000_0001);  expect_o("wrap_s0", 1, 0, 32'hFFFF_FFFF, 0);
    cyc(0, 0, 32'd0);          expect_o("wrap_s1", 1, 1, 32'h0000_0002, 0);
    expect_cnt("wrap_cnt", 16'd2);

    // Back-to-back frames {3,3} {4}
    cyc(1, 0, 32'd3);
    cyc(1, 1, 32'd3);   expect_o("b2b_a0", 1, 0, 32'd3, 0);
    cyc(1, 1, 32'd4);   expect_o("b2b_a1", 1, 1, 32'd0, 0);
    cyc(0, 0, 32'd0);   expect_o("b2b_b0", 1, 1, 32'd4, 0);
    expect_cnt("b2b_cnt", 16'd4);

    // Gaps on alternate cycles; one gap carries a stray last_i
    cyc(1, 0, 32'd1);
    cyc(0, 1, 32'd99);  expect_o("gap_s0", 1, 0, 32'd1, 0);
    cyc(1, 0, 32'd3);   expect_o("gap_g0", 0, 0, 32'd1, 0);
    cyc(0, 0, 32'd0);   expect_o("gap_s1", 1, 0, 32'd2, 0);
    cyc(1, 0, 32'd6);   expect_o("gap_g1", 0, 0, 32'd2, 0);
    cyc(0, 0, 32'd0);   expect_o("gap_s2", 1, 0, 32'd3, 0);
    cyc(1, 1, 32'd9);   expect_o("gap_g2", 0, 0, 32'd3, 0);
    cyc(0, 0, 32'd0);   expect_o("gap_s3", 1, 1, 32'd4, 0);
    expect_cnt("gap_cnt", 16'd5);

    // Reset mid-frame: 7 decoded, 8 abandoned by reset
    cyc(1, 0, 32'd7);
    cyc(1, 0, 32'd8);   expect_o("rst_s0", 1, 0, 32'd7, 0);
    rst = 1'b1;
    cyc(0, 0, 32'd0);   expect_o("rst_clr", 0, 0, 32'd0, 0);
    expect_cnt("rst_cnt0", 16'd0);
    rst = 1'b0;
    cyc(1, 1, 32'd10);
    cyc(0, 0, 32'd0);   expect_o("rst_new", 1, 1, 32'd10, 0);
    expect_cnt("rst_cnt1", 16'd1);

    // Five sums of 1 with no last, MAX_LEN = 4
    cyc(1, 0, 32'd1);
    cyc(1, 0, 32'd1);   expect_o("len_s0", 1, 0, 32'd1, 0);
    cyc(1, 0, 32'd1);   expect_o("len_s1", 1, 0, 32'd0, 0);
    cyc(1, 0, 32'd1);   expect_o("len_s2", 1, 0, 32'd0, 0);
    cyc(1, 0, 32'd1);
`ifdef MOVING_SUM_INV_LEN_CHECK_EN
    expect_o("len_s3", 1, 1, 32'd1, 1);
    cyc(0, 0, 32'd0);   expect_o("len_s4", 1, 0, 32'd1, 0);
    expect_cnt("len_cnt", 16'd2);
`else
    expect_o("len_s3", 1, 0, 32'd1, 0);
    cyc(0, 0, 32'd0);   expect_o("len_s4", 1, 0, 32'd0, 0);
    expect_cnt("len_cnt", 16'd1);
`endif
    cyc(0, 0, 32'd0);   expect_o("len_idle", 0, 0, out === 32'd1 ? 32'd1 : 32'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
